datapath_controller: RTL and testbench

Instruction register, decoder and Moore FSM that sequences the 16-bit register-file/ALU datapath for one instruction at a time. It latches a 16-bit instruction, then drives readnum/writenum, the loada/loadb/loadc/loads/write enables and the asel/bsel/vsel/shift/ALUop selects over 2–5 cycles. It also supplies the sign-extended immediates and a wait flag to the surrounding CPU/testbench.

---
 rtl/datapath_controller_pkg.sv | 58 +++++
 rtl/datapath_controller_instr_dec.sv | 55 +++++
 rtl/datapath_controller.sv | 138 +++++++++++++
 tb/tb_datapath_controller.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/datapath_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : datapath_controller_pkg
// Description : Shared encodings for the datapath controller: opcode/op
//               fields, ALU and shifter codes, instruction classes, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package datapath_controller_pkg;

  // Opcode field IR[15:13]
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  // op field IR[12:11] for OP_MOV
  localparam logic [1:0] MOV_REG = 2'b00;
  localparam logic [1:0] MOV_IMM = 2'b10;

  // op field IR[12:11] for OP_ALU
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  // ALUop codes presented to the datapath
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_AND  = 2'b10;
  localparam logic [1:0] ALUOP_NOTB = 2'b11;

  // Shifter codes carried in IR[4:3]
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  // Instruction class produced by the decoder
  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_MOV_IMM = 3'd1,
    CLS_MOV_REG = 3'd2,
    CLS_ALU     = 3'd3,   // ADD or AND: read Rn and Rm, write Rd
    CLS_CMP     = 3'd4,
    CLS_MVN     = 3'd5
  } instr_cls_t;

  // Controller states; unreachable encodings recover to S_WAIT
  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_DECODE = 3'd1,
    S_GETA   = 3'd2,
    S_GETB   = 3'd3,
    S_EXEC   = 3'd4,
    S_WREG   = 3'd5,
    S_WIMM   = 3'd6
  } state_t;

endpackage : datapath_controller_pkg
`default_nettype wire

// File: rtl/datapath_controller_instr_dec.sv
`default_nettype none
// ============================================================================
// Module      : datapath_controller_instr_dec
// Description : Combinational instruction decoder: register fields, shift
//               code, ALUop, sign-extended immediates and instruction class.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_controller_instr_dec
  import datapath_controller_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [15:0]      i_ir,
  output logic [2:0]       o_rn,
  output logic [2:0]       o_rd,
  output logic [2:0]       o_rm,
  output logic [1:0]       o_sh,
  output logic [1:0]       o_aluop,
  output logic [WIDTH-1:0] o_sximm8,
  output logic [WIDTH-1:0] o_sximm5,
  output instr_cls_t       o_cls
);

  logic [2:0] w_opcode;
  logic [1:0] w_op;

  assign w_opcode = i_ir[15:13];
  assign w_op     = i_ir[12:11];

  assign o_rn     = i_ir[10:8];
  assign o_rd     = i_ir[7:5];
  assign o_sh     = i_ir[4:3];
  assign o_rm     = i_ir[2:0];
  assign o_sximm8 = {{(WIDTH-8){i_ir[7]}}, i_ir[7:0]};
  assign o_sximm5 = {{(WIDTH-5){i_ir[4]}}, i_ir[4:0]};

  // Classify the instruction and pick the ALU operation it needs
  always_comb begin
    o_cls   = CLS_ILLEGAL;
    o_aluop = ALUOP_ADD;
    if (w_opcode == OP_MOV) begin
      if (w_op == MOV_IMM) o_cls = CLS_MOV_IMM;
      else if (w_op == MOV_REG) o_cls = CLS_MOV_REG;   // 0 + shifted Rm
    end else if (w_opcode == OP_ALU) begin
      unique case (w_op)
        ALU_ADD: begin o_cls = CLS_ALU; o_aluop = ALUOP_ADD;  end
        ALU_CMP: begin o_cls = CLS_CMP; o_aluop = ALUOP_SUB;  end
        ALU_AND: begin o_cls = CLS_ALU; o_aluop = ALUOP_AND;  end
        default: begin o_cls = CLS_MVN; o_aluop = ALUOP_NOTB; end
      endcase
    end
  end

endmodule : datapath_controller_instr_dec
`default_nettype wire

// File: rtl/datapath_controller.sv
`default_nettype none
// ============================================================================
// Module      : datapath_controller
// Description : Instruction register plus Moore FSM sequencing the register
//               file / ALU datapath through one instruction at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_controller
  import datapath_controller_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [15:0]      in,
  input  logic             s,
  output logic             w,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             write,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic             vsel,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic [WIDTH-1:0] sximm8,
  output logic [WIDTH-1:0] sximm5
);

  logic [15:0] r_ir;
  state_t      r_state;
  state_t      w_next_state;

  logic [2:0]  w_rn;
  logic [2:0]  w_rd;
  logic [2:0]  w_rm;
  logic [1:0]  w_sh;
  logic [1:0]  w_aluop;
  instr_cls_t  w_cls;

  datapath_controller_instr_dec #(
    .WIDTH (WIDTH)
  ) u_dec (
    .i_ir     (r_ir),
    .o_rn     (w_rn),
    .o_rd     (w_rd),
    .o_rm     (w_rm),
    .o_sh     (w_sh),
    .o_aluop  (w_aluop),
    .o_sximm8 (sximm8),
    .o_sximm5 (sximm5),
    .o_cls    (w_cls)
  );

  // Instruction register: only writable while idle so IR is stable mid-instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        r_ir <= 16'h0000;
    else if (load && r_state == S_WAIT) r_ir <= in;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_WAIT;
    else       r_state <= w_next_state;
  end

  // Next-state and Moore outputs; depend only on r_state and r_ir (plus s for transition)
  always_comb begin
    w_next_state = S_WAIT;
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 1'b0;
    shift    = w_sh;
    ALUop    = w_aluop;
    unique case (r_state)
      S_WAIT: begin
        w = 1'b1;
        w_next_state = s ? S_DECODE : S_WAIT;
      end
      S_DECODE: begin
        unique case (w_cls)
          CLS_MOV_IMM:          w_next_state = S_WIMM;
          CLS_MOV_REG, CLS_MVN: w_next_state = S_GETB;  // single-operand: skip A
          CLS_ALU, CLS_CMP:     w_next_state = S_GETA;
          default:              w_next_state = S_WAIT;
        endcase
      end
      S_GETA: begin
        readnum = w_rn;
        loada   = 1'b1;
        w_next_state = S_GETB;
      end
      S_GETB: begin
        readnum = w_rm;
        loadb   = 1'b1;
        w_next_state = S_EXEC;
      end
      S_EXEC: begin
        // Force A to zero so MOV reg yields shifted Rm and MVN yields ~Rm
        asel = (w_cls == CLS_MOV_REG) || (w_cls == CLS_MVN);
        if (w_cls == CLS_CMP) begin
          loads = 1'b1;
          w_next_state = S_WAIT;
        end else begin
          loadc = 1'b1;
          w_next_state = S_WREG;
        end
      end
      S_WREG: begin
        writenum = w_rd;
        write    = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WIMM: begin
        writenum = w_rn;
        vsel     = 1'b1;
        write    = 1'b1;
        w_next_state = S_WAIT;
      end
      default: w_next_state = S_WAIT;
    endcase
  end

endmodule : datapath_controller
`default_nettype wire

// File: tb/tb_datapath_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_datapath_controller
// Description : Self-checking bench for datapath_controller: vector table,
//               cycle-by-cycle reference schedule, reset and busy corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_controller;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset, load, s;
  logic [15:0]      in;
  logic             w, write, loada, loadb, loadc, loads, asel, bsel, vsel;
  logic [2:0]       readnum, writenum;
  logic [1:0]       shift, ALUop;
  logic [WIDTH-1:0] sximm8, sximm5;

  int n_cmp = 0;
  int n_bad = 0;

  datapath_controller #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .load(load), .in(in), .s(s),
    .w(w), .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8), .sximm5(sximm5)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Observable control bundle {w,readnum,writenum,write,loada,loadb,loadc,loads,asel,bsel,vsel,shift}
  function automatic logic [16:0] obs();
    return {w, readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel, vsel, shift};
  endfunction

  function automatic logic [16:0] mk(input bit iw, input logic [2:0] rn, input logic [2:0] wn,
                                     input bit wr, input bit la, input bit lb, input bit lc,
                                     input bit ls, input bit as, input bit vs, input logic [1:0] sh);
    return {iw, rn, wn, wr, la, lb, lc, ls, as, 1'b0, vs, sh};
  endfunction

  // Reference schedule: one record per cycle after the s edge, ending in the idle cycle
  typedef struct {
    logic [16:0] v;
    bit          exec;
    logic [1:0]  alu;
  } exp_t;
  exp_t exp_q[$];

  task automatic model(input logic [15:0] ir);
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    bit mov_imm, mov_reg, is_alu, is_mvn, is_cmp;
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8]; rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
    mov_imm = (opc == 3'b110) && (op == 2'b10);
    mov_reg = (opc == 3'b110) && (op == 2'b00);
    is_alu  = (opc == 3'b101);
    is_mvn  = is_alu && (op == 2'b11);
    is_cmp  = is_alu && (op == 2'b01);
    exp_q.delete();
    exp_q.push_back('{mk(0,0,0,0,0,0,0,0,0,0,sh), 1'b0, 2'b00});            // decode
    if (mov_imm) begin
      exp_q.push_back('{mk(0,0,rn,1,0,0,0,0,0,1,sh), 1'b0, 2'b00});
    end else if (mov_reg || is_mvn) begin
      exp_q.push_back('{mk(0,rm,0,0,0,1,0,0,0,0,sh), 1'b0, 2'b00});
      exp_q.push_back('{mk(0,0,0,0,0,0,1,0,1,0,sh), 1'b1, is_mvn ? 2'b11 : 2'b00});
      exp_q.push_back('{mk(0,0,rd,1,0,0,0,0,0,0,sh), 1'b0, 2'b00});
    end else if (is_alu) begin
      exp_q.push_back('{mk(0,rn,0,0,1,0,0,0,0,0,sh), 1'b0, 2'b00});
      exp_q.push_back('{mk(0,rm,0,0,0,1,0,0,0,0,sh), 1'b0, 2'b00});
      exp_q.push_back('{mk(0,0,0,0,0,0,!is_cmp,is_cmp,0,0,sh), 1'b1, op});
      if (!is_cmp) exp_q.push_back('{mk(0,0,rd,1,0,0,0,0,0,0,sh), 1'b0, 2'b00});
    end
    exp_q.push_back('{mk(1,0,0,0,0,0,0,0,0,0,sh), 1'b0, 2'b00});            // idle again
  endtask

  // Launch ir (load and s together) and check every cycle against the schedule.
  // With noise set, load/s/in are kept busy with a different word while executing.
  task automatic run_instr(input logic [15:0] ir, input bit noise);
    logic [15:0] sx8, sx5;
    sx8 = {{8{ir[7]}}, ir[7:0]};
    sx5 = {{11{ir[4]}}, ir[4:0]};
    in = ir; load = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    if (noise) begin in = 16'hD0FF; load = 1'b1; s = 1'b1; end
    else       begin load = 1'b0; s = 1'b0; end
    model(ir);
    foreach (exp_q[k]) begin
      if (k > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      check($sformatf("seq %h cyc%0d ctrl", ir, k + 1), 32'(obs()), 32'(exp_q[k].v));
      if (exp_q[k].exec) check($sformatf("seq %h ALUop", ir), 32'(ALUop), 32'(exp_q[k].alu));
      check($sformatf("seq %h cyc%0d sximm8", ir, k + 1), 32'(sximm8), 32'(sx8));
      check($sformatf("seq %h cyc%0d sximm5", ir, k + 1), 32'(sximm5), 32'(sx5));
    end
    load = 1'b0; s = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [15:0] instr;
    int          edges;   // clock edges after the s edge until w=1
    int          writes;
    logic [2:0]  wnum;
    logic [15:0] sx8;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int cnt, nw;
    logic [2:0] lastw;
    logic [15:0] r;

    tbl[0] = '{16'hD007, 2, 1, 3'd0, 16'h0007};
    tbl[1] = '{16'hD1FE, 2, 1, 3'd1, 16'hFFFE};
    tbl[2] = '{16'hA148, 5, 1, 3'd2, 16'h0048};
    tbl[3] = '{16'hA900, 4, 0, 3'd0, 16'h0000};
    tbl[4] = '{16'hC091, 4, 1, 3'd4, 16'hFF91};
    tbl[5] = '{16'hB860, 4, 1, 3'd3, 16'h0060};
    tbl[6] = '{16'hE000, 1, 0, 3'd0, 16'h0000};

    reset = 1'b1; load = 1'b0; s = 1'b0; in = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ctrl", 32'(obs()), 32'(mk(1,0,0,0,0,0,0,0,0,0,2'b00)));
    check("reset ALUop", 32'(ALUop), 32'd0);
    check("reset sximm8", 32'(sximm8), 32'd0);
    check("reset sximm5", 32'(sximm5), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Vector table: latency, write count, destination and immediate
    for (int i = 0; i < 7; i++) begin
      in = tbl[i].instr; load = 1'b1; s = 1'b1;
      @(posedge clk); #1;
      load = 1'b0; s = 1'b0;
      cnt = 0; nw = 0; lastw = 3'd0;
      while (cnt <= 12) begin
        @(negedge clk);
        if (w) break;
        if (write) begin nw++; lastw = writenum; end
        cnt++;
        @(posedge clk); #1;
      end
      check($sformatf("tbl %h latency", tbl[i].instr), 32'(cnt), 32'(tbl[i].edges));
      check($sformatf("tbl %h writes", tbl[i].instr), 32'(nw), 32'(tbl[i].writes));
      check($sformatf("tbl %h writenum", tbl[i].instr), 32'(lastw), 32'(tbl[i].wnum));
      check($sformatf("tbl %h sximm8", tbl[i].instr), 32'(sximm8), 32'(tbl[i].sx8));
      @(posedge clk); #1;
    end

    // Cycle-accurate schedules for the named instructions
    run_instr(16'hD007, 1'b0);
    run_instr(16'hA148, 1'b0);
    run_instr(16'hA900, 1'b0);
    run_instr(16'hC091, 1'b0);
    run_instr(16'hB860, 1'b0);
    run_instr(16'hE000, 1'b0);

    // Load and s held during a busy ADD must be ignored
    run_instr(16'hA148, 1'b1);

    // Reset asserted while fetching B of an ADD
    in = 16'hA148; load = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre-reset loadb", 32'(loadb), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("mid-reset write", 32'(write), 32'd0);
    check("mid-reset loadb", 32'(loadb), 32'd0);
    check("mid-reset w", 32'(w), 32'd1);
    check("mid-reset sximm8", 32'(sximm8), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    run_instr(16'hD1FE, 1'b0);

    // Randomized instructions, biased toward legal opcodes
    for (int i = 0; i < 60; i++) begin
      r = 16'($urandom);
      case ($urandom_range(0, 3))
        0: r[15:13] = 3'b110;
        1, 2: r[15:13] = 3'b101;
        default: ;
      endcase
      run_instr(r, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_datapath_controller
`default_nettype wire
